// File: rtl/quiz_pkg.sv
// Shared types and constants for the factorization quiz round sequencer.
// Holds the FSM state encoding, database word field positions and LFSR setup.
package quiz_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAITQ  = 3'd2,
    S_LOAD   = 3'd3,
    S_ANSWER = 3'd4,
    S_JUDGE  = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  localparam int Q_DIG_HI = 23;
  localparam int Q_DIG_LO = 12;
  localparam int ANS_HI   = 11;
  localparam int ANS_LO   = 0;

  localparam logic [3:0] LFSR_SEED = 4'b0001;
  // Feedback taps for x^4+x^3+1 (bits 3 and 2 of a left-shifting register)
  localparam logic [3:0] LFSR_TAPS = 4'b1100;

  function automatic logic [3:0] lfsr_next(input logic [3:0] cur);
    return {cur[2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/q_select.sv
// Question number selection: free-running LFSR mapped into 1..NUM_Q with
// repeat avoidance, or a plain 1,2,3,... sequence when RANDOM is 0.
module q_select
  import quiz_pkg::*;
#(
  parameter int NUM_Q  = 10,
  parameter int RANDOM = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       clear,
  input  logic       take,
  output logic [3:0] sel
);

  localparam logic [3:0] NUM_Q_L = 4'(NUM_Q);

  logic [3:0] lfsr_r;
  logic [3:0] prev_r;
  logic [3:0] seq_r;
  logic [3:0] mapped_s;
  logic [3:0] rand_s;

  // Fold the LFSR value into range and step past last round's number
  always_comb begin
    mapped_s = lfsr_r;
    rand_s   = lfsr_r;
    sel      = seq_r;
    if (lfsr_r > NUM_Q_L) begin
      mapped_s = lfsr_r - NUM_Q_L;
    end else begin
      mapped_s = lfsr_r;
    end
    if (mapped_s == prev_r) begin
      rand_s = (mapped_s == NUM_Q_L) ? 4'd1 : mapped_s + 4'd1;
    end else begin
      rand_s = mapped_s;
    end
    if (RANDOM != 0) begin
      sel = rand_s;
    end else begin
      sel = seq_r;
    end
  end

  // LFSR runs every cycle; previous number and sequence advance per issued round
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lfsr_r <= LFSR_SEED;
      prev_r <= 4'd0;
      seq_r  <= 4'd1;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
      if (clear) begin
        prev_r <= 4'd0;
        seq_r  <= 4'd1;
      end else if (take) begin
        prev_r <= sel;
        seq_r  <= (seq_r == NUM_Q_L) ? 4'd1 : seq_r + 4'd1;
      end
    end
  end

endmodule

// File: rtl/quiz_ctrl.sv
// Round sequencer for the 1-player factorization quiz: fetches questions,
// times each answer window, judges the submission and keeps score.
module quiz_ctrl
  import quiz_pkg::*;
#(
  parameter int NUM_Q   = 10,
  parameter int ROUNDS  = 5,
  parameter int TIMEOUT = 500_000_000,
  parameter int RANDOM  = 1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [11:0] ANS_IN,
  input  logic        ANS_VALID,
  input  logic [23:0] QUESTION,
  output logic [3:0]  NUM_OUT,
  output logic [11:0] Q_DIGITS,
  output logic        BUSY,
  output logic        CORRECT,
  output logic        WRONG,
  output logic        TIMED_OUT,
  output logic [3:0]  SCORE,
  output logic [3:0]  ROUND,
  output logic        DONE
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0] ROUNDS_L = 4'(ROUNDS);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [11:0]      ans_key_r;
  logic [11:0]      ans_cap_r;
  logic             no_score_r;
  logic [3:0]       num_out_r;
  logic [11:0]      q_digits_r;
  logic             busy_r;
  logic             correct_r;
  logic             wrong_r;
  logic             timed_out_r;
  logic [3:0]       score_r;
  logic [3:0]       round_r;
  logic             done_r;
  logic [3:0]       sel_s;
  logic             clear_s;
  logic             take_s;

  q_select #(
    .NUM_Q (NUM_Q),
    .RANDOM(RANDOM)
  ) u_q_select (
    .CLK  (CLK),
    .RST_N(RST_N),
    .clear(clear_s),
    .take (take_s),
    .sel  (sel_s)
  );

  // Game start and question issue strobes for the selector
  always_comb begin
    clear_s = 1'b0;
    take_s  = 1'b0;
    if (START && (state_r == S_IDLE || state_r == S_FINISH)) begin
      clear_s = 1'b1;
    end else begin
      clear_s = 1'b0;
    end
    if (state_r == S_ISSUE) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  // Round sequencing FSM with registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      ans_key_r   <= 12'd0;
      ans_cap_r   <= 12'd0;
      no_score_r  <= 1'b0;
      num_out_r   <= 4'd0;
      q_digits_r  <= 12'd0;
      busy_r      <= 1'b0;
      correct_r   <= 1'b0;
      wrong_r     <= 1'b0;
      timed_out_r <= 1'b0;
      score_r     <= 4'd0;
      round_r     <= 4'd0;
      done_r      <= 1'b0;
    end else begin
      correct_r   <= 1'b0;
      wrong_r     <= 1'b0;
      timed_out_r <= 1'b0;
      case (state_r)
        S_IDLE, S_FINISH: begin
          if (START) begin
            score_r    <= 4'd0;
            round_r    <= 4'd1;
            done_r     <= 1'b0;
            busy_r     <= 1'b1;
            q_digits_r <= 12'd0;
            state_r    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          num_out_r <= sel_s;
          state_r   <= S_WAITQ;
        end
        S_WAITQ: begin
          state_r <= S_LOAD;
        end
        S_LOAD: begin
          q_digits_r <= QUESTION[Q_DIG_HI:Q_DIG_LO];
          ans_key_r  <= QUESTION[ANS_HI:ANS_LO];
          cnt_r      <= '0;
          state_r    <= S_ANSWER;
        end
        S_ANSWER: begin
          // A submission on the terminal count cycle still counts as an answer
          if (ANS_VALID) begin
            ans_cap_r  <= ANS_IN;
            no_score_r <= 1'b0;
            state_r    <= S_JUDGE;
          end else if (cnt_r == CNT_LAST) begin
            timed_out_r <= 1'b1;
            no_score_r  <= 1'b1;
            state_r     <= S_JUDGE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        S_JUDGE: begin
          if (!no_score_r) begin
            if (ans_cap_r == ans_key_r) begin
              correct_r <= 1'b1;
              score_r   <= score_r + 4'd1;
            end else begin
              wrong_r <= 1'b1;
            end
          end
          if (round_r == ROUNDS_L) begin
            done_r    <= 1'b1;
            busy_r    <= 1'b0;
            num_out_r <= 4'd0;
            state_r   <= S_FINISH;
          end else begin
            round_r <= round_r + 4'd1;
            state_r <= S_ISSUE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign NUM_OUT   = num_out_r;
  assign Q_DIGITS  = q_digits_r;
  assign BUSY      = busy_r;
  assign CORRECT   = correct_r;
  assign WRONG     = wrong_r;
  assign TIMED_OUT = timed_out_r;
  assign SCORE     = score_r;
  assign ROUND     = round_r;
  assign DONE      = done_r;

endmodule

// File: tb/tb_quiz_ctrl.sv
// Self-checking bench for quiz_ctrl: a sequential-mode instance with a short
// timeout for the round flow, and a random-mode instance for question selection.
module tb_quiz_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        start0 = 1'b0, ans_valid0 = 1'b0;
  logic [11:0] ans_in0 = 12'd0;
  logic [23:0] question0 = 24'd0;
  logic [3:0]  num_out0, score0, round0;
  logic [11:0] q_digits0;
  logic        busy0, correct0, wrong0, timed_out0, done0;

  logic        start1 = 1'b0, ans_valid1 = 1'b0;
  logic [11:0] ans_in1 = 12'd0;
  logic [23:0] question1 = 24'd0;
  logic [3:0]  num_out1, score1, round1;
  logic [11:0] q_digits1;
  logic        busy1, correct1, wrong1, timed_out1, done1;

  quiz_ctrl #(.NUM_Q(10), .ROUNDS(3), .TIMEOUT(100), .RANDOM(0)) dut0 (
    .CLK(clk), .RST_N(rst_n), .START(start0), .ANS_IN(ans_in0), .ANS_VALID(ans_valid0),
    .QUESTION(question0), .NUM_OUT(num_out0), .Q_DIGITS(q_digits0), .BUSY(busy0),
    .CORRECT(correct0), .WRONG(wrong0), .TIMED_OUT(timed_out0), .SCORE(score0),
    .ROUND(round0), .DONE(done0));

  quiz_ctrl #(.NUM_Q(10), .ROUNDS(5), .TIMEOUT(4), .RANDOM(1)) dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .ANS_IN(ans_in1), .ANS_VALID(ans_valid1),
    .QUESTION(question1), .NUM_OUT(num_out1), .Q_DIGITS(q_digits1), .BUSY(busy1),
    .CORRECT(correct1), .WRONG(wrong1), .TIMED_OUT(timed_out1), .SCORE(score1),
    .ROUND(round1), .DONE(done1));

  // Question database contents: {question digits, answer nibbles}
  function automatic logic [23:0] rom_word(input logic [3:0] n);
    case (n)
      4'd0:    return 24'h000000;
      4'd1:    return 24'h027222;
      4'd2:    return 24'h042237;
      4'd3:    return 24'h030235;
      default: return {4'h0, 4'h1, n, n, n, 4'h1};
    endcase
  endfunction

  // Registered database read, one cycle of latency
  always @(posedge clk) begin
    question0 <= rom_word(num_out0);
    question1 <= rom_word(num_out1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game0();
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({num_out0, q_digits0, busy0, correct0, wrong0, timed_out0, score0, round0, done0} !== 37'd0) begin
      failures++;
      $display("FAIL reset_dut0 got=%0h exp=0", {num_out0, q_digits0, busy0, correct0, wrong0, timed_out0, score0, round0, done0});
    end
    checks++;
    if ({num_out1, q_digits1, busy1, correct1, wrong1, timed_out1, score1, round1, done1} !== 37'd0) begin
      failures++;
      $display("FAIL reset_dut1 got=%0h exp=0", {num_out1, q_digits1, busy1, correct1, wrong1, timed_out1, score1, round1, done1});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_flow();
    start_game0();
    checks++;
    if ({busy0, round0, score0, done0} !== {1'b1, 4'd1, 4'd0, 1'b0}) begin
      failures++; $display("FAIL start_state got=%0h exp=%0h", {busy0, round0, score0, done0}, {1'b1, 4'd1, 4'd0, 1'b0});
    end
    tick();
    checks++;
    if (num_out0 !== 4'd1) begin failures++; $display("FAIL r1_num got=%0d exp=1", num_out0); end
    tick(); tick();
    checks++;
    if (q_digits0 !== 12'h027) begin failures++; $display("FAIL r1_digits got=%0h exp=027", q_digits0); end
    ans_in0 = 12'h222; ans_valid0 = 1'b1;
    tick();
    ans_valid0 = 1'b0;
    checks++;
    if (correct0 !== 1'b0) begin failures++; $display("FAIL r1_early_pulse got=%0b exp=0", correct0); end
    tick();
    checks++;
    if ({correct0, wrong0, timed_out0, score0, round0} !== {3'b100, 4'd1, 4'd2}) begin
      failures++; $display("FAIL r1_correct got=%0h exp=%0h", {correct0, wrong0, timed_out0, score0, round0}, {3'b100, 4'd1, 4'd2});
    end
    tick();
    checks++;
    if (num_out0 !== 4'd2) begin failures++; $display("FAIL r2_num got=%0d exp=2", num_out0); end
    tick(); tick();
    checks++;
    if (q_digits0 !== 12'h042) begin failures++; $display("FAIL r2_digits got=%0h exp=042", q_digits0); end
    ans_in0 = 12'h123; ans_valid0 = 1'b1;
    tick();
    ans_valid0 = 1'b0;
    tick();
    checks++;
    if ({correct0, wrong0, timed_out0, score0, round0} !== {3'b010, 4'd1, 4'd3}) begin
      failures++; $display("FAIL r2_wrong got=%0h exp=%0h", {correct0, wrong0, timed_out0, score0, round0}, {3'b010, 4'd1, 4'd3});
    end
    tick();
    checks++;
    if (num_out0 !== 4'd3) begin failures++; $display("FAIL r3_num got=%0d exp=3", num_out0); end
    tick(); tick();
    repeat (99) tick();
    checks++;
    if (timed_out0 !== 1'b0) begin failures++; $display("FAIL r3_timeout_early got=%0b exp=0", timed_out0); end
    tick();
    checks++;
    if ({correct0, wrong0, timed_out0} !== 3'b001) begin
      failures++; $display("FAIL r3_timeout got=%0b exp=001", {correct0, wrong0, timed_out0});
    end
    tick();
    checks++;
    if ({done0, busy0, num_out0, score0, round0, correct0, wrong0, timed_out0, q_digits0} !==
        {1'b1, 1'b0, 4'd0, 4'd1, 4'd3, 3'b000, 12'h030}) begin
      failures++; $display("FAIL finish_state got=%0h exp=%0h", {done0, busy0, num_out0, score0, round0, correct0, wrong0, timed_out0, q_digits0},
                           {1'b1, 1'b0, 4'd0, 4'd1, 4'd3, 3'b000, 12'h030});
    end
  endtask

  task automatic test_coincident();
    start_game0();
    checks++;
    if (q_digits0 !== 12'h000) begin failures++; $display("FAIL restart_clear_digits got=%0h exp=0", q_digits0); end
    tick(); tick(); tick();
    repeat (99) tick();
    ans_in0 = 12'h222; ans_valid0 = 1'b1;
    tick();
    ans_valid0 = 1'b0;
    checks++;
    if (timed_out0 !== 1'b0) begin failures++; $display("FAIL coincident_no_timeout got=%0b exp=0", timed_out0); end
    tick();
    checks++;
    if ({correct0, wrong0, timed_out0, score0} !== {3'b100, 4'd1}) begin
      failures++; $display("FAIL coincident_correct got=%0h exp=%0h", {correct0, wrong0, timed_out0, score0}, {3'b100, 4'd1});
    end
  endtask

  task automatic test_ignored();
    logic seen;
    // now in ISSUE of round 2; submit the right answer early plus a restart request
    start0 = 1'b1; ans_valid0 = 1'b1; ans_in0 = 12'h237;
    tick(); tick();
    start0 = 1'b0; ans_valid0 = 1'b0;
    tick();
    checks++;
    if ({round0, busy0, q_digits0} !== {4'd2, 1'b1, 12'h042}) begin
      failures++; $display("FAIL ignore_issue got=%0h exp=%0h", {round0, busy0, q_digits0}, {4'd2, 1'b1, 12'h042});
    end
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      seen = seen | correct0 | wrong0 | timed_out0;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL ignore_no_queue got=%0b exp=0", seen); end
    ans_in0 = 12'h000; ans_valid0 = 1'b1;
    tick();
    start0 = 1'b1; ans_in0 = 12'h237;
    tick();
    start0 = 1'b0; ans_valid0 = 1'b0;
    checks++;
    if ({correct0, wrong0, timed_out0, round0, score0} !== {3'b010, 4'd3, 4'd1}) begin
      failures++; $display("FAIL ignore_judge got=%0h exp=%0h", {correct0, wrong0, timed_out0, round0, score0}, {3'b010, 4'd3, 4'd1});
    end
    tick();
    checks++;
    if (num_out0 !== 4'd3) begin failures++; $display("FAIL ignore_no_restart got=%0d exp=3", num_out0); end
    tick(); tick(); tick(); tick();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({num_out0, q_digits0, busy0, correct0, wrong0, timed_out0, score0, round0, done0} !== 37'd0) begin
      failures++; $display("FAIL async_reset got=%0h exp=0", {num_out0, q_digits0, busy0, correct0, wrong0, timed_out0, score0, round0, done0});
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy0, round0, correct0, wrong0, timed_out0} !== 7'd0) begin
      failures++; $display("FAIL reset_idle got=%0h exp=0", {busy0, round0, correct0, wrong0, timed_out0});
    end
  endtask

  task automatic test_random_seq();
    int exp_score, act, d;
    logic [23:0] w;
    logic [2:0] exp_p;
    for (int g = 0; g < 6; g++) begin
      repeat ($urandom_range(0, 3)) tick();
      start_game0();
      exp_score = 0;
      for (int r = 1; r <= 3; r++) begin
        tick();
        checks++;
        if (num_out0 !== 4'(((r - 1) % 10) + 1)) begin
          failures++; $display("FAIL seq_num g=%0d r=%0d got=%0d exp=%0d", g, r, num_out0, ((r - 1) % 10) + 1);
        end
        w = rom_word(4'(((r - 1) % 10) + 1));
        tick(); tick();
        checks++;
        if (q_digits0 !== w[23:12]) begin failures++; $display("FAIL seq_digits got=%0h exp=%0h", q_digits0, w[23:12]); end
        act = $urandom_range(0, 2);
        if (act < 2) begin
          d = $urandom_range(0, 99);
          repeat (d) tick();
          ans_in0 = (act == 0) ? w[11:0] : w[11:0] ^ 12'($urandom_range(1, 4095));
          ans_valid0 = 1'b1;
          tick();
          ans_valid0 = 1'b0;
          tick();
          exp_p = (act == 0) ? 3'b100 : 3'b010;
          if (act == 0) exp_score++;
        end else begin
          repeat (100) tick();
          checks++;
          if (timed_out0 !== 1'b1) begin failures++; $display("FAIL seq_timeout got=%0b exp=1", timed_out0); end
          tick();
          exp_p = 3'b000;
        end
        checks++;
        if ({correct0, wrong0, timed_out0} !== exp_p) begin
          failures++; $display("FAIL seq_pulse g=%0d r=%0d got=%0b exp=%0b", g, r, {correct0, wrong0, timed_out0}, exp_p);
        end
        checks++;
        if ({score0, round0, done0} !== {4'(exp_score), 4'((r < 3) ? r + 1 : 3), (r == 3)}) begin
          failures++; $display("FAIL seq_score g=%0d r=%0d got=%0h exp=%0h", g, r, {score0, round0, done0},
                               {4'(exp_score), 4'((r < 3) ? r + 1 : 3), (r == 3)});
        end
      end
    end
  endtask

  task automatic test_random_select();
    int prev, n, exp_score, ok_ans;
    logic [23:0] w;
    for (int g = 0; g < 200; g++) begin
      repeat ($urandom_range(0, 7)) tick();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      prev = 0;
      exp_score = 0;
      for (int r = 1; r <= 5; r++) begin
        tick();
        n = int'(num_out1);
        checks++;
        if (n < 1 || n > 10 || n == prev) begin
          failures++; $display("FAIL rand_num g=%0d r=%0d got=%0d prev=%0d exp=1..10 and not prev", g, r, n, prev);
        end
        prev = n;
        w = rom_word(4'(n));
        tick(); tick();
        checks++;
        if (q_digits1 !== w[23:12]) begin failures++; $display("FAIL rand_digits got=%0h exp=%0h", q_digits1, w[23:12]); end
        ok_ans = $urandom_range(0, 1);
        ans_in1 = (ok_ans == 1) ? w[11:0] : ~w[11:0];
        ans_valid1 = 1'b1;
        tick();
        ans_valid1 = 1'b0;
        tick();
        if (ok_ans == 1) exp_score++;
        checks++;
        if ({correct1, wrong1, timed_out1, score1, done1} !== {(ok_ans == 1), (ok_ans == 0), 1'b0, 4'(exp_score), (r == 5)}) begin
          failures++; $display("FAIL rand_judge g=%0d r=%0d got=%0h exp=%0h", g, r, {correct1, wrong1, timed_out1, score1, done1},
                               {(ok_ans == 1), (ok_ans == 0), 1'b0, 4'(exp_score), (r == 5)});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_flow();
    test_coincident();
    test_ignored();
    test_random_seq();
    test_random_select();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quiz_ctrl.md
# quiz_ctrl

Round sequencer for the 1-player factorization quiz. Picks question numbers, fetches each question from the question database (registered ROM, 1-cycle latency, 24-bit word = 3 BCD question digits in [23:12] and 3 answer nibbles in [11:0]), and holds the question digits for display. It then accepts one answer submission per round with a timeout, judges it, and keeps score until the configured number of rounds is complete. Sits between the player input/debounce logic and the database/display.

## Interface
- NUM_Q, 10: valid database entries are 1..NUM_Q (entry 0 reserved as blank)
- ROUNDS, 5: rounds per game, 1..15
- TIMEOUT, 500_000_000: answer window in CLK cycles, ≥2
- RANDOM, 1: 1 = LFSR question selection, 0 = sequential 1,2,3,… (verification mode)

- CLK  in  1  system clock
- RST_N  in  1  asynchronous, active-low reset
- START  in  1  single-cycle pulse, starts/restarts a game
- ANS_IN  in  12  player answer, three nibbles
- ANS_VALID  in  1  single-cycle submit strobe
- QUESTION  in  24  database read data
- NUM_OUT  out  4  database address (to database NUM_IN)
- Q_DIGITS  out  12  latched question digits QUESTION[23:12]
- BUSY  out  1  high from START acceptance until DONE
- CORRECT  out  1  1-cycle pulse, answer matched
- WRONG  out  1  1-cycle pulse, answer mismatched
- TIMED_OUT  out  1  1-cycle pulse, window expired
- SCORE  out  4  correct answers this game
- ROUND  out  4  current round number, 1-based
- DONE  out  1  level, game finished

## Operation
- All outputs registered; reset value 0 for every output, state IDLE, LFSR = 4'b0001.
- States: IDLE, ISSUE, WAITQ, LOAD, ANSWER, JUDGE, FINISH.
- IDLE/FINISH: START → clear SCORE, ROUND=1, DONE=0, BUSY=1, go ISSUE. START in any other state ignored.
- ISSUE: NUM_OUT ← selected number; go WAITQ.
- WAITQ: one cycle for database register; go LOAD.
- LOAD: Q_DIGITS ← QUESTION[23:12], internal answer ← QUESTION[11:0]; clear timeout counter; go ANSWER.
- ANSWER: counter increments each cycle. ANS_VALID → capture ANS_IN, go JUDGE. Counter reaching TIMEOUT-1 without ANS_VALID → TIMED_OUT pulse, go JUDGE with no-score flag. ANS_VALID in the same cycle as terminal count: answer wins.
- JUDGE: match → CORRECT pulse, SCORE+1; mismatch → WRONG pulse. Exactly one of CORRECT/WRONG/TIMED_OUT per round. If ROUND==ROUNDS → FINISH (DONE=1, BUSY=0, NUM_OUT=0); else ROUND+1, go ISSUE.
- ANS_VALID outside ANSWER ignored; does not queue.
- Selection, RANDOM=1: 4-bit LFSR x^4+x^3+1 advances every cycle; value v>NUM_Q maps to v−NUM_Q. If the result equals the previous round's number, use +1, wrapping NUM_Q→1. Never outputs 0 during a game.
- Selection, RANDOM=0: round r uses ((r−1) mod NUM_Q)+1.
- Q_DIGITS held through FINISH; cleared on next START.
- Reset mid-game: immediate return to IDLE, all outputs 0, game lost.

## Timing
- START edge → NUM_OUT valid after 1 cycle (ISSUE) → database data after 2 → Q_DIGITS valid 3 cycles after START sampled.
- ANS_VALID sampled at edge e → result pulse asserted for the cycle after e+1 (JUDGE registered).
- Round-to-round gap (JUDGE → next ANSWER): 4 cycles.
- Timeout: TIMED_OUT asserted TIMEOUT cycles after entering ANSWER.
- SCORE/ROUND update in the same edge as the result pulse.

## Structure
- quiz_pkg: state enum, field constants (Q_DIG_HI=23, Q_DIG_LO=12, ANS_HI=11, ANS_LO=0), LFSR seed/taps.
- One sub-module: q_select (LFSR plus range mapping and repeat avoidance, NUM_Q and RANDOM parameters); timeout counter and FSM stay in quiz_ctrl.

## Test plan
- RANDOM=0, ROUNDS=3, TIMEOUT=100, database loaded: START → NUM_OUT 1, Q_DIGITS=12'h027 three cycles later; ANS_IN=12'h222 → CORRECT, SCORE=1, ROUND=2.
- Round 2: NUM_OUT 2, Q_DIGITS=12'h042; ANS_IN=12'h123 → WRONG, SCORE stays 1.
- Round 3: no ANS_VALID → TIMED_OUT exactly 100 cycles after ANSWER entry, then DONE=1, BUSY=0, NUM_OUT=0, SCORE=1.
- ANS_VALID coincident with terminal count cycle → CORRECT/WRONG only, no TIMED_OUT.
- START and ANS_VALID pulses during ISSUE/WAITQ/JUDGE → ignored, ROUND unchanged; RST_N low mid-ANSWER → all outputs 0 asynchronously, IDLE.
- RANDOM=1, 200 games: every NUM_OUT in 1..10 during a game, never equal on consecutive rounds.
